ysyx_23060059_axi_rd_xbar: RTL and testbench

- Parametrised AXI4 read-path interconnect: NM masters (IFU, LSU, future DMA) share two read slaves.
  - Slave 0 is memory.
  - Slave 1 is the device window (UART etc.).
- Unmapped addresses are answered by an internal DECERR responder.
- Round-robin arbitration replaces the old fixed A-over-B priority.
- Supports full bursts (arlen, rlast) and one outstanding transaction.
- Sits between the core's AXI masters and the SoC slave ports.

---
 rtl/ysyx_23060059_axi_pkg.sv | 29 ++
 rtl/ysyx_23060059_rr_pick.sv | 34 +++
 rtl/ysyx_23060059_axi_rd_xbar.sv | 199 +++++++++++++++++++
 tb/tb_ysyx_23060059_axi_rd_xbar.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060059_axi_pkg.sv
// Shared definitions for the AXI4 read crossbar.
//   RESP_*      : AXI read response codes used by the crossbar
//   tgt_e       : decoded destination of a read request
//   state_e     : crossbar FSM states
//   *_DEF       : default address windows for memory and the device region
package ysyx_23060059_axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [31:0] DEV_BASE_DEF = 32'ha000_0000;
   localparam logic [31:0] DEV_SIZE_DEF = 32'h0001_0000;
   localparam logic [31:0] MEM_BASE_DEF = 32'h8000_0000;
   localparam logic [31:0] MEM_SIZE_DEF = 32'h0800_0000;

   typedef enum logic [1:0] {
      TGT_MEM = 2'd0,
      TGT_DEV = 2'd1,
      TGT_ERR = 2'd2
   } tgt_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      AR   = 2'd1,
      R    = 2'd2,
      ERRR = 2'd3
   } state_e;

endpackage

// File: rtl/ysyx_23060059_rr_pick.sv
// Combinational round-robin picker.
//   req : request vector, one bit per master
//   ptr : highest-priority index this round (always < NM)
//   gnt : one-hot grant, all zero when nothing requests
//   idx : index of the granted master (0 when nothing requests)
module ysyx_23060059_rr_pick #(
   parameter int unsigned NM = 2,
   parameter int unsigned IW = 1
) (
   input  logic [NM-1:0] req,
   input  logic [IW-1:0] ptr,
   output logic [NM-1:0] gnt,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] cand;
   logic          found;

   // Walk from ptr upward, wrapping modulo NM; the first requester wins.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned k = 0; k < NM; k++) begin
         cand = IW'((32'(ptr) + k) % NM);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      gnt = found ? (NM'(1) << idx) : '0;
   end

endmodule

// File: rtl/ysyx_23060059_axi_rd_xbar.sv
// AXI4 read-path crossbar: NM masters share a memory slave (0) and a device slave (1).
// Unmapped addresses are answered internally with DECERR. One transaction in flight.
//   m_ar* / m_r* : master-side AR and R channels (R data/resp/id/last shared)
//   s_ar* / s_r* : slave-side AR and R channels (AR payload shared, valid/ready per slave)
module ysyx_23060059_axi_rd_xbar
   import ysyx_23060059_axi_pkg::*;
#(
   parameter int unsigned NM       = 2,
   parameter logic [31:0] DEV_BASE = DEV_BASE_DEF,
   parameter logic [31:0] DEV_SIZE = DEV_SIZE_DEF,
   parameter logic [31:0] MEM_BASE = MEM_BASE_DEF,
   parameter logic [31:0] MEM_SIZE = MEM_SIZE_DEF
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [NM-1:0]   m_arvalid,
   output logic [NM-1:0]   m_arready,
   input  logic [NM*32-1:0] m_araddr,
   input  logic [NM*4-1:0] m_arid,
   input  logic [NM*8-1:0] m_arlen,
   input  logic [NM*3-1:0] m_arsize,
   input  logic [NM*2-1:0] m_arburst,
   output logic [NM-1:0]   m_rvalid,
   input  logic [NM-1:0]   m_rready,
   output logic [63:0]     m_rdata,
   output logic [1:0]      m_rresp,
   output logic [3:0]      m_rid,
   output logic            m_rlast,
   output logic [1:0]      s_arvalid,
   input  logic [1:0]      s_arready,
   output logic [31:0]     s_araddr,
   output logic [3:0]      s_arid,
   output logic [7:0]      s_arlen,
   output logic [2:0]      s_arsize,
   output logic [1:0]      s_arburst,
   input  logic [1:0]      s_rvalid,
   output logic [1:0]      s_rready,
   input  logic [127:0]    s_rdata,
   input  logic [3:0]      s_rresp,
   input  logic [7:0]      s_rid,
   input  logic [1:0]      s_rlast
);

   localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1;

   state_e        state_q, state_d;
   tgt_e          tgt_q, tgt_d;
   logic [IW-1:0] grant_q, grant_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [7:0]    beat_cnt_q, beat_cnt_d;
   logic [3:0]    arid_q, arid_d;
   logic [7:0]    arlen_q, arlen_d;

   logic [NM-1:0] pick_gnt;
   logic [IW-1:0] pick_idx;
   logic [31:0]   pick_addr;
   logic          slv;
   logic [IW-1:0] rr_next;

   ysyx_23060059_rr_pick #(
      .NM (NM),
      .IW (IW)
   ) u_pick (
      .req (m_arvalid),
      .ptr (rr_ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx)
   );

   // 33-bit compares so a window ending at 2^32 does not wrap to zero.
   function automatic tgt_e decode(input logic [31:0] a);
      logic [32:0] x;
      x = {1'b0, a};
      if (x >= {1'b0, DEV_BASE} && x < ({1'b0, DEV_BASE} + {1'b0, DEV_SIZE})) begin
         return TGT_DEV;
      end else if (x >= {1'b0, MEM_BASE} && x < ({1'b0, MEM_BASE} + {1'b0, MEM_SIZE})) begin
         return TGT_MEM;
      end
      return TGT_ERR;
   endfunction

   assign pick_addr = m_araddr[32*pick_idx +: 32];
   assign slv       = (tgt_q == TGT_DEV);
   assign rr_next   = (grant_q == IW'(NM - 1)) ? '0 : grant_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      tgt_d      = tgt_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      arid_d     = arid_q;
      arlen_d    = arlen_q;
      unique case (state_q)
         IDLE: begin
            if (|pick_gnt) begin
               grant_d = pick_idx;
               tgt_d   = decode(pick_addr);
               arid_d  = m_arid[4*pick_idx +: 4];
               arlen_d = m_arlen[8*pick_idx +: 8];
               state_d = AR;
            end
         end
         AR: begin
            // The error responder accepts the address unconditionally.
            if (tgt_q == TGT_ERR) begin
               beat_cnt_d = arlen_q;
               state_d    = ERRR;
            end else if (s_arready[slv]) begin
               state_d = R;
            end
         end
         R: begin
            if (s_rvalid[slv] && m_rready[grant_q] && s_rlast[slv]) begin
               rr_ptr_d = rr_next;
               state_d  = IDLE;
            end
         end
         ERRR: begin
            if (m_rready[grant_q]) begin
               if (beat_cnt_q == 8'd0) begin
                  rr_ptr_d = rr_next;
                  state_d  = IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q - 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      m_arready = '0;
      m_rvalid  = '0;
      m_rdata   = '0;
      m_rresp   = '0;
      m_rid     = '0;
      m_rlast   = 1'b0;
      s_arvalid = '0;
      s_araddr  = '0;
      s_arid    = '0;
      s_arlen   = '0;
      s_arsize  = '0;
      s_arburst = '0;
      s_rready  = '0;
      unique case (state_q)
         AR: begin
            if (tgt_q == TGT_ERR) begin
               m_arready[grant_q] = 1'b1;
            end else begin
               s_arvalid[slv]     = 1'b1;
               s_araddr           = m_araddr[32*grant_q +: 32];
               s_arid             = m_arid[4*grant_q +: 4];
               s_arlen            = m_arlen[8*grant_q +: 8];
               s_arsize           = m_arsize[3*grant_q +: 3];
               s_arburst          = m_arburst[2*grant_q +: 2];
               m_arready[grant_q] = s_arready[slv];
            end
         end
         R: begin
            m_rvalid[grant_q] = s_rvalid[slv];
            s_rready[slv]     = m_rready[grant_q];
            m_rdata           = s_rdata[64*slv +: 64];
            m_rresp           = s_rresp[2*slv +: 2];
            m_rid             = s_rid[4*slv +: 4];
            m_rlast           = s_rlast[slv];
         end
         ERRR: begin
            m_rvalid[grant_q] = 1'b1;
            m_rresp           = RESP_DECERR;
            m_rid             = arid_q;
            m_rlast           = (beat_cnt_q == 8'd0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         tgt_q      <= TGT_MEM;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         arid_q     <= '0;
         arlen_q    <= '0;
      end else begin
         state_q    <= state_d;
         tgt_q      <= tgt_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         arid_q     <= arid_d;
         arlen_q    <= arlen_d;
      end
   end

endmodule

// File: tb/tb_ysyx_23060059_axi_rd_xbar.sv
// Directed bench for the AXI read crossbar: a table of single-master transactions, then
// round-robin, mid-burst reset sequences. Slaves are modelled inline by the driving task.
module tb_ysyx_23060059_axi_rd_xbar;

   localparam int NM = 2;

   logic            clock;
   logic            reset;
   logic [NM-1:0]   m_arvalid;
   logic [NM-1:0]   m_arready;
   logic [NM*32-1:0] m_araddr;
   logic [NM*4-1:0] m_arid;
   logic [NM*8-1:0] m_arlen;
   logic [NM*3-1:0] m_arsize;
   logic [NM*2-1:0] m_arburst;
   logic [NM-1:0]   m_rvalid;
   logic [NM-1:0]   m_rready;
   logic [63:0]     m_rdata;
   logic [1:0]      m_rresp;
   logic [3:0]      m_rid;
   logic            m_rlast;
   logic [1:0]      s_arvalid;
   logic [1:0]      s_arready;
   logic [31:0]     s_araddr;
   logic [3:0]      s_arid;
   logic [7:0]      s_arlen;
   logic [2:0]      s_arsize;
   logic [1:0]      s_arburst;
   logic [1:0]      s_rvalid;
   logic [1:0]      s_rready;
   logic [127:0]    s_rdata;
   logic [3:0]      s_rresp;
   logic [7:0]      s_rid;
   logic [1:0]      s_rlast;

   ysyx_23060059_axi_rd_xbar #(
      .NM (NM)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .m_arvalid (m_arvalid),
      .m_arready (m_arready),
      .m_araddr  (m_araddr),
      .m_arid    (m_arid),
      .m_arlen   (m_arlen),
      .m_arsize  (m_arsize),
      .m_arburst (m_arburst),
      .m_rvalid  (m_rvalid),
      .m_rready  (m_rready),
      .m_rdata   (m_rdata),
      .m_rresp   (m_rresp),
      .m_rid     (m_rid),
      .m_rlast   (m_rlast),
      .s_arvalid (s_arvalid),
      .s_arready (s_arready),
      .s_araddr  (s_araddr),
      .s_arid    (s_arid),
      .s_arlen   (s_arlen),
      .s_arsize  (s_arsize),
      .s_arburst (s_arburst),
      .s_rvalid  (s_rvalid),
      .s_rready  (s_rready),
      .s_rdata   (s_rdata),
      .s_rresp   (s_rresp),
      .s_rid     (s_rid),
      .s_rlast   (s_rlast)
   );

   // slv: 0 memory, 1 device, 2 internal error responder
   typedef struct {
      int          m;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [3:0]  id;
      int          slv;
      int          stall;
      bit          toggle;
      logic [63:0] data;
      logic [1:0]  resp;
   } txn_t;

   int n_total = 0;
   int n_pass  = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic clear_slaves();
      s_arready = '0;
      s_rvalid  = '0;
      s_rdata   = '0;
      s_rresp   = '0;
      s_rid     = '0;
      s_rlast   = '0;
   endtask

   // Entered at a negedge with the DUT in IDLE; leaves at a negedge with the DUT in IDLE.
   task automatic serve(input txn_t t);
      int          b;
      int          cyc;
      bit          rdy;
      logic [63:0] srdy;
      m_arvalid[t.m]          = 1'b1;
      m_araddr[32*t.m +: 32]  = t.addr;
      m_arid[4*t.m +: 4]      = t.id;
      m_arlen[8*t.m +: 8]     = t.len;
      m_arsize[3*t.m +: 3]    = 3'd3;
      m_arburst[2*t.m +: 2]   = 2'd1;
      #1;
      check("idle_arready", 64'(m_arready), 64'd0);
      check("idle_s_arvalid", 64'(s_arvalid), 64'd0);
      @(negedge clock);
      if (t.slv != 2) begin
         s_arready[t.slv] = 1'b1;
         #1;
         check("ar_s_arvalid", 64'(s_arvalid), 64'(1) << t.slv);
         check("ar_s_araddr", 64'(s_araddr), 64'(t.addr));
         check("ar_s_arlen", 64'(s_arlen), 64'(t.len));
         check("ar_s_arid", 64'(s_arid), 64'(t.id));
         check("ar_s_arsize", 64'(s_arsize), 64'd3);
         check("ar_s_arburst", 64'(s_arburst), 64'd1);
         check("ar_m_arready", 64'(m_arready), 64'(1) << t.m);
      end else begin
         #1;
         check("err_s_arvalid", 64'(s_arvalid), 64'd0);
         check("err_s_araddr", 64'(s_araddr), 64'd0);
         check("err_m_arready", 64'(m_arready), 64'(1) << t.m);
      end
      @(negedge clock);
      m_arvalid[t.m] = 1'b0;
      s_arready      = '0;
      for (int i = 0; i < t.stall; i++) begin
         m_rready[t.m] = 1'b1;
         #1;
         check("stall_m_rvalid", 64'(m_rvalid), 64'd0);
         check("stall_s_rready", 64'(s_rready), 64'(1) << t.slv);
         @(negedge clock);
      end
      b   = 0;
      cyc = 0;
      rdy = 1'b1;
      while (b <= int'(t.len) && cyc < 64) begin
         m_rready[t.m] = rdy;
         if (t.slv != 2) begin
            s_rvalid[t.slv]          = 1'b1;
            s_rdata[64*t.slv +: 64]  = t.data + 64'(b);
            s_rresp[2*t.slv +: 2]    = 2'b00;
            s_rid[4*t.slv +: 4]      = t.id;
            s_rlast[t.slv]           = (b == int'(t.len));
         end
         #1;
         srdy = (t.slv != 2 && rdy) ? (64'(1) << t.slv) : 64'd0;
         check("r_m_rvalid", 64'(m_rvalid), 64'(1) << t.m);
         check("r_m_rdata", m_rdata, (t.slv == 2) ? 64'd0 : t.data + 64'(b));
         check("r_m_rresp", 64'(m_rresp), 64'(t.resp));
         check("r_m_rid", 64'(m_rid), 64'(t.id));
         check("r_m_rlast", 64'(m_rlast), 64'(b == int'(t.len)));
         check("r_s_rready", 64'(s_rready), srdy);
         check("r_s_arvalid", 64'(s_arvalid), 64'd0);
         check("r_m_arready", 64'(m_arready), 64'd0);
         if (rdy) b++;
         if (t.toggle) rdy = ~rdy;
         cyc++;
         @(negedge clock);
      end
      clear_slaves();
      m_rready = '0;
      #1;
      check("done_m_rvalid", 64'(m_rvalid), 64'd0);
      check("done_m_rdata", m_rdata, 64'd0);
      check("done_m_rlast", 64'(m_rlast), 64'd0);
      check("done_m_rresp", 64'(m_rresp), 64'd0);
      check("done_s_rready", 64'(s_rready), 64'd0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   txn_t tbl[8];
   txn_t rr[4];

   initial begin
      tbl[0] = '{0, 32'h8000_0000, 8'd0, 4'h1, 0, 0, 1'b0, 64'h0000_0000_dead_beef, 2'b00};
      tbl[1] = '{1, 32'ha000_03f8, 8'd3, 4'h5, 1, 5, 1'b0, 64'h0000_0000_0000_0055, 2'b00};
      tbl[2] = '{0, 32'h0000_1000, 8'd2, 4'h9, 2, 0, 1'b0, 64'd0, 2'b11};
      tbl[3] = '{1, 32'h87ff_fff8, 8'd3, 4'h2, 0, 1, 1'b1, 64'h1111_2222_3333_4440, 2'b00};
      tbl[4] = '{0, 32'h8800_0000, 8'd1, 4'h3, 2, 0, 1'b1, 64'd0, 2'b11};
      tbl[5] = '{1, 32'ha000_ffff, 8'd0, 4'h7, 1, 0, 1'b0, 64'h0000_0000_0000_0a5a, 2'b00};
      tbl[6] = '{0, 32'ha001_0000, 8'd0, 4'hc, 2, 0, 1'b0, 64'd0, 2'b11};
      tbl[7] = '{1, 32'h7fff_fffc, 8'd0, 4'hf, 2, 0, 1'b0, 64'd0, 2'b11};

      rr[0] = '{0, 32'h8000_1000, 8'd0, 4'h1, 0, 0, 1'b0, 64'h0000_0000_0000_a000, 2'b00};
      rr[1] = '{1, 32'h8000_2000, 8'd0, 4'h2, 0, 0, 1'b0, 64'h0000_0000_0000_b000, 2'b00};
      rr[2] = '{0, 32'h8000_3000, 8'd1, 4'h3, 0, 0, 1'b0, 64'h0000_0000_0000_c000, 2'b00};
      rr[3] = '{1, 32'h8000_4000, 8'd0, 4'h4, 0, 0, 1'b0, 64'h0000_0000_0000_d000, 2'b00};

      reset     = 1'b1;
      m_arvalid = '0;
      m_araddr  = '0;
      m_arid    = '0;
      m_arlen   = '0;
      m_arsize  = '0;
      m_arburst = '0;
      m_rready  = '0;
      clear_slaves();
      do_reset();
      #1;
      check("rst_m_arready", 64'(m_arready), 64'd0);
      check("rst_m_rvalid", 64'(m_rvalid), 64'd0);
      check("rst_s_arvalid", 64'(s_arvalid), 64'd0);
      check("rst_m_rdata", m_rdata, 64'd0);

      for (int i = 0; i < 8; i++) serve(tbl[i]);

      // Round-robin: both masters request at each arbitration; expected order 0,1,0,1.
      do_reset();
      m_arvalid[1]       = 1'b1;
      m_araddr[63:32]    = rr[1].addr;
      m_arid[7:4]        = rr[1].id;
      m_arlen[15:8]      = rr[1].len;
      serve(rr[0]);
      m_arvalid[0]       = 1'b1;
      m_araddr[31:0]     = rr[2].addr;
      m_arid[3:0]        = rr[2].id;
      m_arlen[7:0]       = rr[2].len;
      serve(rr[1]);
      m_arvalid[1]       = 1'b1;
      m_araddr[63:32]    = rr[3].addr;
      m_arid[7:4]        = rr[3].id;
      m_arlen[15:8]      = rr[3].len;
      serve(rr[2]);
      serve(rr[3]);

      // Reset during beat 2 of a 4-beat memory burst.
      m_arvalid[0]   = 1'b1;
      m_araddr[31:0] = 32'h8000_0100;
      m_arid[3:0]    = 4'h6;
      m_arlen[7:0]   = 8'd3;
      @(negedge clock);
      s_arready[0] = 1'b1;
      @(negedge clock);
      m_arvalid[0] = 1'b0;
      s_arready    = '0;
      m_rready[0]  = 1'b1;
      s_rvalid[0]  = 1'b1;
      s_rdata[63:0] = 64'h100;
      s_rid[3:0]   = 4'h6;
      #1;
      check("rst_burst_beat1", 64'(m_rvalid), 64'd1);
      @(negedge clock);
      s_rdata[63:0] = 64'h101;
      reset         = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("rst_mid_m_rvalid", 64'(m_rvalid), 64'd0);
      check("rst_mid_s_rready", 64'(s_rready), 64'd0);
      check("rst_mid_m_rdata", m_rdata, 64'd0);
      check("rst_mid_m_rid", 64'(m_rid), 64'd0);
      check("rst_mid_s_arvalid", 64'(s_arvalid), 64'd0);
      check("rst_mid_m_arready", 64'(m_arready), 64'd0);
      clear_slaves();
      m_rready = '0;
      serve(tbl[3]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
